rb_param: RTL and testbench
===========================

Name: rb_param

Overview:
- Parametrised register bank for the microcoded datapath; next generation of the fixed 35x16 bank.
- Holds GPRs, input/output port registers, aux registers and one working register (WR), all configurable.
- Two combinational read ports (busA/busB) with write-forwarding, and one write port (busC).
- Handshaked memory load/store engine on WR, with timeout and error reporting.

Parameters:
DW, 16, data width of every register and bus
NGPR, 28, number of general-purpose registers (indices 0..NGPR-1)
NIN, 2, number of input-port registers, placed after the GPRs
NOUT, 2, number of output-port registers, placed after the inputs
NAUX, 2, number of aux registers, placed after the outputs
AW, 6, address width of busA/busB/WRC; must satisfy 2^AW >= NREG
TMO, 15, memory handshake timeout in cycles (>=1)
Derived: NREG = NGPR+NIN+NOUT+NAUX+1; WR index = NREG-1 (34 at defaults).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
MC  in  2  bit0 MW (store WR to memory), bit1 MR (load memory into WR); sampled only when idle
WRC  in  AW  busC destination index
wr_en  in  1  busC write enable
busA  in  AW  read index, operand A
busB  in  AW  read index, operand B
busC  in  DW  write data
Mdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion strobe
in_port  in  NIN*DW  external inputs, port k in bits [k*DW +: DW]
A  out  DW  operand A (combinational)
B  out  DW  operand B (combinational)
WRdata  out  DW  store data, held stable for the whole store
mem_req  out  1  memory request, level
mem_we  out  1  1 = store, 0 = load; valid while mem_req
busy  out  1  memory engine not idle
err  out  1  sticky error: timeout or illegal MC
out_port  out  NOUT*DW  output-port register contents

Behaviour:
- Reset (async, rst=1): all registers 0; out_port, WRdata, mem_req, mem_we, busy and err are 0; FSM goes to IDLE. Reset mid-transaction aborts it, with no WR update.
- Input ports: register NGPR+k <= in_port[k] every cycle (1-cycle latency). busC writes to these indices are ignored.
- busC write: if wr_en, WRC < NREG and WRC is not an input index, then Register[WRC] <= busC. Writes to WR are ignored while busy.
- Reads: A = Register[busA], B = Register[busB]. Index >= NREG reads 0.
- Forwarding: if the same cycle has an accepted busC write to the read index, the read returns busC.
- Forwarding: in the mem_ack cycle of a load, a read of WR returns Mdata.
- FSM states IDLE, LOAD, STORE.
  - IDLE: MC=2'b10 -> LOAD. MC=2'b01 -> STORE, latching WRdata <= WR (a busC write to WR in the same cycle is not seen). MC=2'b11 -> stay IDLE and set err. MC=2'b00 -> stay IDLE.
  - LOAD: mem_req=1, mem_we=0, busy=1. On mem_ack: WR <= Mdata, then IDLE.
  - STORE: mem_req=1, mem_we=1, busy=1. On mem_ack: return to IDLE.
- Latency: request asserted the cycle after MC is sampled. busy deasserts the cycle after mem_ack.
- Back-to-back operation: a new MC can be accepted in the cycle busy is low.
- Timeout: a counter resets on state entry. If mem_ack has not arrived after TMO cycles in LOAD or STORE, go to IDLE and set err; WR is unchanged. mem_ack in the same cycle as the timeout wins.
- mem_ack while IDLE: ignored.
- MC while busy: ignored.
- err clears only on reset.

Decomposition:
- Shared package rb_pkg holds:
  - index-base helper functions (GPR, IN, OUT, AUX, WR bases from the parameters);
  - the MC encoding constants MC_NONE, MC_STORE, MC_LOAD, MC_ILLEGAL;
  - the state enum.
- One sub-module, rb_mem_ctrl: FSM, timeout counter, WRdata latch, err.
- Storage and forwarding stay in the top.

Test Plan:
- Reset, then wr_en=1, WRC=5, busC=16'hBEEF with busA=5 in the same cycle -> A=16'hBEEF (forwarded); after the edge A=16'hBEEF from storage.
- in_port[0]=16'h1234 and a write to index 28 with busC=0 -> busA=28 reads 16'h1234 one cycle after in_port is applied; the write is ignored.
- WR=16'h00AA, MC=01 -> next cycle mem_req=1, mem_we=1, WRdata=16'h00AA; mem_ack after 3 cycles -> busy=0; err=0.
- MC=10, Mdata=16'h5A5A with mem_ack on the 2nd wait cycle, busA=34 -> A=16'h5A5A in the ack cycle; WR=16'h5A5A afterwards.
- MC=10 with no mem_ack -> after 15 cycles mem_req=0, busy=0, err=1; WR unchanged. Apply MC=11 separately -> err=1 and no request.
- Assert rst during a store wait -> all outputs 0 immediately (asynchronous), including the sticky err; a subsequent mem_ack is ignored.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the parametrised register bank: index bases,
// MC command encodings and the memory-engine state type.
package rb_pkg;

  localparam logic [1:0] MC_NONE    = 2'b00;
  localparam logic [1:0] MC_STORE   = 2'b01;
  localparam logic [1:0] MC_LOAD    = 2'b10;
  localparam logic [1:0] MC_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE
  } rb_state_e;

  function automatic int unsigned gpr_base();
    return 0;
  endfunction

  function automatic int unsigned in_base(input int unsigned ngpr);
    return ngpr;
  endfunction

  function automatic int unsigned out_base(input int unsigned ngpr, input int unsigned nin);
    return ngpr + nin;
  endfunction

  function automatic int unsigned aux_base(input int unsigned ngpr, input int unsigned nin,
                                           input int unsigned nout);
    return ngpr + nin + nout;
  endfunction

  function automatic int unsigned wr_index(input int unsigned ngpr, input int unsigned nin,
                                           input int unsigned nout, input int unsigned naux);
    return ngpr + nin + nout + naux;
  endfunction

endpackage

// File: rtl/rb_mem_ctrl.sv
// Memory load/store engine for WR: request/ack handshake, timeout,
// store-data latch and sticky error flag.
module rb_mem_ctrl
  import rb_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mc_i,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] wr_q_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [DW-1:0] wrdata_o,
  output logic          load_done_o
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  rb_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [DW-1:0] wrdata_q;
  logic          timeout;

  assign timeout = (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mc_i == MC_LOAD)       state_d = ST_LOAD;
        else if (mc_i == MC_STORE) state_d = ST_STORE;
      end
      ST_LOAD, ST_STORE: begin
        if (mem_ack_i || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state_q != ST_IDLE);
    mem_we_o    = (state_q == ST_STORE);
    busy_o      = (state_q != ST_IDLE);
    load_done_o = (state_q == ST_LOAD) && mem_ack_i;
  end

  // Counter holds zero in IDLE, so every LOAD/STORE entry starts the count afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        cnt_q <= '0;
    else if (state_q == ST_IDLE || state_d != state_q) cnt_q <= '0;
    else                                            cnt_q <= cnt_q + 1'b1;
  end

  // An ack arriving in the timeout cycle completes normally, without error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_IDLE && mc_i == MC_ILLEGAL) ||
                 (state_q != ST_IDLE && !mem_ack_i && timeout)) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        wrdata_q <= '0;
    else if (state_q == ST_IDLE && mc_i == MC_STORE) wrdata_q <= wr_q_i;
  end

  assign err_o    = err_q;
  assign wrdata_o = wrdata_q;

endmodule

// File: rtl/rb_param.sv
// Parametrised register bank: GPR/in/out/aux registers plus WR, two
// forwarded combinational read ports, one write port and the WR memory engine.
module rb_param
  import rb_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned NGPR = 28,
  parameter int unsigned NIN  = 2,
  parameter int unsigned NOUT = 2,
  parameter int unsigned NAUX = 2,
  parameter int unsigned AW   = 6,
  parameter int unsigned TMO  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         MC,
  input  logic [AW-1:0]      WRC,
  input  logic               wr_en,
  input  logic [AW-1:0]      busA,
  input  logic [AW-1:0]      busB,
  input  logic [DW-1:0]      busC,
  input  logic [DW-1:0]      Mdata,
  input  logic               mem_ack,
  input  logic [NIN*DW-1:0]  in_port,
  output logic [DW-1:0]      A,
  output logic [DW-1:0]      B,
  output logic [DW-1:0]      WRdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic               busy,
  output logic               err,
  output logic [NOUT*DW-1:0] out_port
);

  localparam int unsigned IN_B  = in_base(NGPR);
  localparam int unsigned OUT_B = out_base(NGPR, NIN);
  localparam int unsigned WR_I  = wr_index(NGPR, NIN, NOUT, NAUX);
  localparam int unsigned NREG  = WR_I + 1;

  localparam logic [AW:0] NREG_X  = (AW+1)'(NREG);
  localparam logic [AW:0] IN_X    = (AW+1)'(IN_B);
  localparam logic [AW:0] OUT_X   = (AW+1)'(OUT_B);
  localparam logic [AW:0] WR_X    = (AW+1)'(WR_I);

  logic [DW-1:0] regs_q [NREG];
  logic          wr_acc;
  logic          load_done;
  logic [AW:0]   wrc_x;

  assign wrc_x  = {1'b0, WRC};
  assign wr_acc = wr_en && (wrc_x < NREG_X) &&
                  !((wrc_x >= IN_X) && (wrc_x < OUT_X)) &&
                  !((wrc_x == WR_X) && busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NIN; k++) regs_q[IN_B + k] <= in_port[k*DW +: DW];
      if (wr_acc)    regs_q[WRC]  <= busC;
      if (load_done) regs_q[WR_I] <= Mdata;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] idx);
    logic [DW-1:0] v;
    v = '0;
    if ({1'b0, idx} < NREG_X)            v = regs_q[idx];
    if (wr_acc && (idx == WRC))          v = busC;
    if (load_done && ({1'b0, idx} == WR_X)) v = Mdata;
    return v;
  endfunction

  always_comb begin
    A = rd_port(busA);
    B = rd_port(busB);
  end

  always_comb begin
    out_port = '0;
    for (int unsigned k = 0; k < NOUT; k++) out_port[k*DW +: DW] = regs_q[OUT_B + k];
  end

  rb_mem_ctrl #(
    .DW  (DW),
    .TMO (TMO)
  ) u_mem_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mc_i        (MC),
    .mem_ack_i   (mem_ack),
    .wr_q_i      (regs_q[WR_I]),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .busy_o      (busy),
    .err_o       (err),
    .wrdata_o    (WRdata),
    .load_done_o (load_done)
  );

endmodule

// File: tb/tb_rb_param.sv
// Directed self-checking bench for rb_param at default parameters.
module tb_rb_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MC;
  logic [5:0]  WRC;
  logic        wr_en;
  logic [5:0]  busA;
  logic [5:0]  busB;
  logic [15:0] busC;
  logic [15:0] Mdata;
  logic        mem_ack;
  logic [31:0] in_port;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] WRdata;
  logic        mem_req;
  logic        mem_we;
  logic        busy;
  logic        err;
  logic [31:0] out_port;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n;

  always #5 clk = ~clk;

  rb_param #(
    .DW   (16),
    .NGPR (28),
    .NIN  (2),
    .NOUT (2),
    .NAUX (2),
    .AW   (6),
    .TMO  (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MC       (MC),
    .WRC      (WRC),
    .wr_en    (wr_en),
    .busA     (busA),
    .busB     (busB),
    .busC     (busC),
    .Mdata    (Mdata),
    .mem_ack  (mem_ack),
    .in_port  (in_port),
    .A        (A),
    .B        (B),
    .WRdata   (WRdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .busy     (busy),
    .err      (err),
    .out_port (out_port)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; MC = 2'b00; WRC = '0; wr_en = 1'b0; busA = '0; busB = '0;
    busC = '0; Mdata = '0; mem_ack = 1'b0; in_port = '0;
    #2;
    check("rst_A", {16'h0, A}, 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_wrdata", {16'h0, WRdata}, 32'h0);
    check("rst_out", out_port, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Forwarded and stored GPR write
    wr_en = 1'b1; WRC = 6'd5; busC = 16'hBEEF; busA = 6'd5;
    #1 check("fwd_A", {16'h0, A}, 32'h0000_BEEF);
    tick();
    wr_en = 1'b0; busC = '0;
    check("store_A", {16'h0, A}, 32'h0000_BEEF);

    // Output port register and out-of-range read
    wr_en = 1'b1; WRC = 6'd30; busC = 16'h1111; busB = 6'd40;
    tick();
    wr_en = 1'b0;
    check("out_port0", out_port, 32'h0000_1111);
    check("oor_B", {16'h0, B}, 32'h0);

    // Input port: 1-cycle latency, busC write ignored
    in_port = 32'h0000_1234; wr_en = 1'b1; WRC = 6'd28; busC = 16'h0000; busA = 6'd28;
    #1 check("in_nofwd", {16'h0, A}, 32'h0);
    tick();
    wr_en = 1'b0;
    check("in_read", {16'h0, A}, 32'h0000_1234);

    // Store
    wr_en = 1'b1; WRC = 6'd34; busC = 16'h00AA;
    tick();
    wr_en = 1'b0; MC = 2'b01; busA = 6'd34;
    check("st_idle_busy", {31'h0, busy}, 32'h0);
    tick();
    MC = 2'b00;
    check("st_req", {31'h0, mem_req}, 32'h1);
    check("st_we", {31'h0, mem_we}, 32'h1);
    check("st_wrdata", {16'h0, WRdata}, 32'h0000_00AA);
    wr_en = 1'b1; WRC = 6'd34; busC = 16'hFFFF;
    #1 check("st_wr_blocked", {16'h0, A}, 32'h0000_00AA);
    tick();
    wr_en = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_done_busy", {31'h0, busy}, 32'h0);
    check("st_done_req", {31'h0, mem_req}, 32'h0);
    check("st_err", {31'h0, err}, 32'h0);
    check("st_wr_kept", {16'h0, A}, 32'h0000_00AA);

    // Load with ack on the 2nd wait cycle
    MC = 2'b10;
    tick();
    MC = 2'b00;
    check("ld_req", {31'h0, mem_req}, 32'h1);
    check("ld_we", {31'h0, mem_we}, 32'h0);
    tick();
    Mdata = 16'h5A5A; mem_ack = 1'b1;
    #1 check("ld_fwd_A", {16'h0, A}, 32'h0000_5A5A);
    check("ld_ack_busy", {31'h0, busy}, 32'h1);
    tick();
    mem_ack = 1'b0; Mdata = '0;
    check("ld_wr", {16'h0, A}, 32'h0000_5A5A);
    check("ld_done_busy", {31'h0, busy}, 32'h0);

    // Back-to-back load with no ack: timeout
    MC = 2'b10;
    tick();
    MC = 2'b00;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("tmo_cycles", n, 32'd15);
    check("tmo_busy", {31'h0, busy}, 32'h0);
    check("tmo_err", {31'h0, err}, 32'h1);
    check("tmo_wr", {16'h0, A}, 32'h0000_5A5A);

    // Illegal MC after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err", {31'h0, err}, 32'h0);
    MC = 2'b11;
    tick();
    MC = 2'b00;
    check("ill_err", {31'h0, err}, 32'h1);
    check("ill_req", {31'h0, mem_req}, 32'h0);
    tick();
    check("ill_busy", {31'h0, busy}, 32'h0);

    // Asynchronous reset during a store wait
    wr_en = 1'b1; WRC = 6'd34; busC = 16'h7777; busA = 6'd34;
    tick();
    wr_en = 1'b0; MC = 2'b01;
    tick();
    MC = 2'b00;
    check("ar_req", {31'h0, mem_req}, 32'h1);
    check("ar_wrdata", {16'h0, WRdata}, 32'h0000_7777);
    #2 rst = 1'b1;
    #1;
    check("ar_req0", {31'h0, mem_req}, 32'h0);
    check("ar_busy0", {31'h0, busy}, 32'h0);
    check("ar_we0", {31'h0, mem_we}, 32'h0);
    check("ar_err0", {31'h0, err}, 32'h0);
    check("ar_wrdata0", {16'h0, WRdata}, 32'h0);
    check("ar_out0", out_port, 32'h0);
    tick();
    rst = 1'b0; mem_ack = 1'b1; Mdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("ar_ack_busy", {31'h0, busy}, 32'h0);
    check("ar_ack_req", {31'h0, mem_req}, 32'h0);
    check("ar_ack_wr", {16'h0, A}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
